// File: rtl/washer_plant_feedback_if.sv
// Controller <-> plant bundle: actuator commands and raw door switch in, sensor/timeout feedback out.
// master = controller/testbench side, slave = plant model side.
interface washer_plant_feedback_if #(
  parameter int LEVEL_W = 8
);
  logic               fill_value_on;
  logic               drain_value_on;
  logic               motor_on;
  logic               door_lock;
  logic               soap_wash;
  logic               water_wash;
  logic               done;
  logic               door_sw;
  logic               filled;
  logic               drained;
  logic               detergent_added;
  logic               cycle_timeout;
  logic               spin_timeout;
  logic               door_close;
  logic [LEVEL_W-1:0] water_level;
  logic               fault;

  modport master (
    output fill_value_on, drain_value_on, motor_on, door_lock,
    output soap_wash, water_wash, done, door_sw,
    input  filled, drained, detergent_added, cycle_timeout,
    input  spin_timeout, door_close, water_level, fault
  );

  modport slave (
    input  fill_value_on, drain_value_on, motor_on, door_lock,
    input  soap_wash, water_wash, done, door_sw,
    output filled, drained, detergent_added, cycle_timeout,
    output spin_timeout, door_close, water_level, fault
  );
endinterface

// File: rtl/washer_plant_feedback.sv
// Washer plant model: drum level, detergent doser, wash/spin timers, door debounce.
// Optional fill/valve fault checker is built only when FAULT_DETECT_EN is defined.
module washer_plant_feedback #(
  parameter int LEVEL_W         = 8,
  parameter int LEVEL_MAX       = 200,
  parameter int FILL_RATE       = 4,
  parameter int DRAIN_RATE      = 8,
  parameter int TMR_W           = 16,
  parameter int DOSE_CYCLES     = 16,
  parameter int WASH_CYCLES     = 1000,
  parameter int SPIN_CYCLES     = 500,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int FILL_TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  washer_plant_feedback_if.slave pif
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [LEVEL_W-1:0] LVL_MAX    = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W:0]   FILL_INC   = (LEVEL_W+1)'(FILL_RATE);
  localparam logic [LEVEL_W:0]   LVL_MAX_X  = (LEVEL_W+1)'(LEVEL_MAX);
  localparam logic [LEVEL_W:0]   DRAIN_DEC  = (LEVEL_W+1)'(DRAIN_RATE);
  localparam logic [TMR_W-1:0]   DOSE_LAST  = TMR_W'(DOSE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   WASH_MAX   = TMR_W'(WASH_CYCLES);
  localparam logic [TMR_W-1:0]   SPIN_MAX   = TMR_W'(SPIN_CYCLES);
  localparam logic [DB_W-1:0]    DB_MAX     = DB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    DOSER_IDLE,
    DOSER_DOSE,
    DOSER_DONE
  } doser_e;

  logic [LEVEL_W-1:0] level_q, level_d;
  doser_e             dstate_q, dstate_d;
  logic [TMR_W-1:0]   dose_cnt_q, dose_cnt_d;
  logic               dosed_q, dosed_d;
  logic               det_q, det_d;
  logic [TMR_W-1:0]   wash_q, wash_d;
  logic [TMR_W-1:0]   spin_q, spin_d;
  logic               sw_last_q, sw_last_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               db_q, db_d;

  logic               filled;
  logic               drained;
  logic [LEVEL_W:0]   level_x;
  logic               dose_start;

  assign filled  = (level_q == LVL_MAX);
  assign drained = (level_q == '0);

  // Level arithmetic is one bit wider so the fill clamp cannot wrap.
  always_comb begin
    level_d = level_q;
    level_x = {1'b0, level_q};
    if (pif.fill_value_on && !pif.drain_value_on) begin
      level_x = {1'b0, level_q} + FILL_INC;
      level_d = (level_x > LVL_MAX_X) ? LVL_MAX : level_x[LEVEL_W-1:0];
    end else if (pif.drain_value_on && !pif.fill_value_on) begin
      level_x = ({1'b0, level_q} < DRAIN_DEC) ? '0 : ({1'b0, level_q} - DRAIN_DEC);
      level_d = level_x[LEVEL_W-1:0];
    end
  end

  // Dose only into a full, locked, idle drum, and only once per wash.
  assign dose_start = pif.soap_wash && !pif.water_wash && filled && pif.door_lock &&
                      !dosed_q && !pif.motor_on && !pif.fill_value_on && !pif.drain_value_on;

  always_comb begin
    dstate_d   = dstate_q;
    dose_cnt_d = dose_cnt_q;
    dosed_d    = dosed_q;
    case (dstate_q)
      DOSER_IDLE: begin
        if (dose_start) begin
          dstate_d   = DOSER_DOSE;
          dose_cnt_d = '0;
        end
      end
      DOSER_DOSE: begin
        if (dose_cnt_q == DOSE_LAST) begin
          dstate_d = DOSER_DONE;
          dosed_d  = 1'b1;
        end else begin
          dose_cnt_d = dose_cnt_q + 1'b1;
        end
      end
      DOSER_DONE: begin
        if (pif.motor_on) dstate_d = DOSER_IDLE;
      end
      default: dstate_d = DOSER_IDLE;
    endcase
    if (!pif.door_lock) dstate_d = DOSER_IDLE;
    if (pif.done || !pif.door_lock) dosed_d = 1'b0;
    det_d = (dstate_d == DOSER_DONE);
  end

  always_comb begin
    wash_d = '0;
    if (pif.motor_on) wash_d = (wash_q == WASH_MAX) ? wash_q : wash_q + 1'b1;
  end

  // Spin time only accrues once the drum is empty; the drain valve closing clears it.
  always_comb begin
    spin_d = '0;
    if (pif.drain_value_on) begin
      spin_d = spin_q;
      if (pif.water_wash && drained && (spin_q != SPIN_MAX)) spin_d = spin_q + 1'b1;
    end
  end

  // db_cnt counts consecutive samples equal to the newest one, the first differing sample counting as one.
  always_comb begin
    sw_last_d = pif.door_sw;
    db_cnt_d  = db_cnt_q;
    db_d      = db_q;
    if (pif.door_sw != sw_last_q) begin
      db_cnt_d = DB_W'(1);
    end else if (db_cnt_q != DB_MAX) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    if (db_cnt_d == DB_MAX) db_d = pif.door_sw;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q    <= '0;
      dstate_q   <= DOSER_IDLE;
      dose_cnt_q <= '0;
      dosed_q    <= 1'b0;
      det_q      <= 1'b0;
      wash_q     <= '0;
      spin_q     <= '0;
      sw_last_q  <= 1'b0;
      db_cnt_q   <= '0;
      db_q       <= 1'b0;
    end else begin
      level_q    <= level_d;
      dstate_q   <= dstate_d;
      dose_cnt_q <= dose_cnt_d;
      dosed_q    <= dosed_d;
      det_q      <= det_d;
      wash_q     <= wash_d;
      spin_q     <= spin_d;
      sw_last_q  <= sw_last_d;
      db_cnt_q   <= db_cnt_d;
      db_q       <= db_d;
    end
  end

`ifdef FAULT_DETECT_EN
  localparam logic [TMR_W-1:0] FILL_TO = TMR_W'(FILL_TIMEOUT);

  logic [TMR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic             fault_q, fault_d;

  always_comb begin
    fill_cnt_d = '0;
    if (pif.fill_value_on && !filled)
      fill_cnt_d = (fill_cnt_q == FILL_TO) ? fill_cnt_q : fill_cnt_q + 1'b1;
    fault_d = fault_q || (pif.fill_value_on && pif.drain_value_on) || (fill_cnt_d == FILL_TO);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign pif.fault = fault_q;
`else
  assign pif.fault = 1'b0;
`endif

  assign pif.filled          = filled;
  assign pif.drained         = drained;
  assign pif.detergent_added = det_q;
  assign pif.cycle_timeout   = (wash_q == WASH_MAX);
  assign pif.spin_timeout    = (spin_q == SPIN_MAX);
  assign pif.door_close      = pif.door_lock | db_q;
  assign pif.water_level     = level_q;

endmodule

// File: tb/tb_washer_plant_feedback.sv
// Directed bench for washer_plant_feedback: reset, fill clamp, dosing, timers, door debounce, fault, mid-wash reset.
module tb_washer_plant_feedback;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef FAULT_DETECT_EN
  localparam logic FAULT_EXP = 1'b1;
`else
  localparam logic FAULT_EXP = 1'b0;
`endif

  washer_plant_feedback_if #(.LEVEL_W(8)) pif ();

  washer_plant_feedback dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset              = 1'b0;
    pif.fill_value_on  = 1'b0;
    pif.drain_value_on = 1'b0;
    pif.motor_on       = 1'b0;
    pif.door_lock      = 1'b0;
    pif.soap_wash      = 1'b0;
    pif.water_wash     = 1'b0;
    pif.done           = 1'b0;
    pif.door_sw        = 1'b0;

    // Reset state
    tick(3);
    check("rst_drained", 32'(pif.drained), 1);
    check("rst_filled", 32'(pif.filled), 0);
    check("rst_level", 32'(pif.water_level), 0);
    check("rst_door_close", 32'(pif.door_close), 0);
    check("rst_detergent", 32'(pif.detergent_added), 0);
    check("rst_cycle_to", 32'(pif.cycle_timeout), 0);
    check("rst_spin_to", 32'(pif.spin_timeout), 0);
    check("rst_fault", 32'(pif.fault), 0);

    // Fill ramp with clamp at 200
    reset = 1'b1;
    pif.fill_value_on = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      check("fill_level", 32'(pif.water_level), 32'((4 * i > 200) ? 200 : 4 * i));
      check("fill_filled", 32'(pif.filled), 32'(i >= 50));
    end
    tick(3);
    check("fill_hold_level", 32'(pif.water_level), 200);
    check("fill_hold_drained", 32'(pif.drained), 0);

    // Dosing: 16 dose clocks plus one to enter
    pif.fill_value_on = 1'b0;
    pif.door_lock     = 1'b1;
    pif.soap_wash     = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("dose_progress", 32'(pif.detergent_added), 32'(k == 17));
    end
    check("lock_door_close", 32'(pif.door_close), 1);
    pif.motor_on = 1'b1;
    tick();
    check("dose_motor_clear", 32'(pif.detergent_added), 0);
    pif.motor_on = 1'b0;
    tick(20);
    check("no_redose", 32'(pif.detergent_added), 0);
    check("dose_level_kept", 32'(pif.water_level), 200);

    // Wash timer
    pif.soap_wash = 1'b0;
    pif.motor_on  = 1'b1;
    tick(999);
    check("wash_999", 32'(pif.cycle_timeout), 0);
    tick();
    check("wash_1000", 32'(pif.cycle_timeout), 1);
    tick(5);
    check("wash_held", 32'(pif.cycle_timeout), 1);
    pif.motor_on = 1'b0;
    tick();
    check("wash_clear", 32'(pif.cycle_timeout), 0);

    // Drain, then spin timer on the empty drum
    pif.water_wash     = 1'b1;
    pif.drain_value_on = 1'b1;
    tick();
    check("drain_first", 32'(pif.water_level), 192);
    tick(23);
    check("drain_24_level", 32'(pif.water_level), 8);
    check("drain_24_drained", 32'(pif.drained), 0);
    tick();
    check("drain_25_drained", 32'(pif.drained), 1);
    check("drain_25_level", 32'(pif.water_level), 0);
    tick(499);
    check("spin_499", 32'(pif.spin_timeout), 0);
    tick();
    check("spin_500", 32'(pif.spin_timeout), 1);
    tick(2);
    check("spin_held", 32'(pif.spin_timeout), 1);
    pif.drain_value_on = 1'b0;
    tick();
    check("spin_clear", 32'(pif.spin_timeout), 0);

    // Both valves: level holds, fault only when checker is built
    pif.fill_value_on  = 1'b1;
    pif.drain_value_on = 1'b1;
    tick();
    check("both_level_hold", 32'(pif.water_level), 0);
    check("both_fault", 32'(pif.fault), 32'(FAULT_EXP));
    pif.fill_value_on  = 1'b0;
    pif.drain_value_on = 1'b0;
    tick(3);
    check("fault_sticky", 32'(pif.fault), 32'(FAULT_EXP));

    // Door debounce
    pif.water_wash = 1'b0;
    pif.door_lock  = 1'b0;
    tick();
    check("unlock_door_open", 32'(pif.door_close), 0);
    pif.door_sw = 1'b1;
    tick(3);
    pif.door_sw = 1'b0;
    tick(10);
    check("glitch_ignored", 32'(pif.door_close), 0);
    pif.door_sw = 1'b1;
    tick(7);
    check("debounce_7", 32'(pif.door_close), 0);
    tick();
    check("debounce_8", 32'(pif.door_close), 1);
    pif.door_lock = 1'b1;
    pif.door_sw   = 1'b0;
    tick(10);
    check("locked_open_ignored", 32'(pif.door_close), 1);
    pif.door_lock = 1'b0;
    tick();
    check("unlock_shows_open", 32'(pif.door_close), 0);

    // Reset mid-wash with actuators active
    pif.door_lock     = 1'b1;
    pif.fill_value_on = 1'b1;
    pif.motor_on      = 1'b1;
    tick(5);
    check("midwash_level", 32'(pif.water_level), 20);
    reset = 1'b0;
    tick();
    check("midrst_level", 32'(pif.water_level), 0);
    check("midrst_drained", 32'(pif.drained), 1);
    check("midrst_cycle_to", 32'(pif.cycle_timeout), 0);
    check("midrst_fault", 32'(pif.fault), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
